// File: rtl/hidden_layer_scheduler.sv
// hidden_layer_scheduler: runs the four hidden-layer neurons (N4..N7) one
// after another on a single shared neuron. It latches one input vector,
// issues four jobs with per-job weight columns, captures each 12-bit result
// and then offers the 4-word result downstream. Each job is bounded by a
// timeout; a timed-out job yields 0 and raises its err bit.
module hidden_layer_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [4:0]  in0,
  input  logic signed [4:0]  in1,
  input  logic signed [4:0]  in2,
  input  logic signed [4:0]  in3,
  input  logic signed [4:0]  w04,
  input  logic signed [4:0]  w05,
  input  logic signed [4:0]  w06,
  input  logic signed [4:0]  w07,
  input  logic signed [4:0]  w14,
  input  logic signed [4:0]  w15,
  input  logic signed [4:0]  w16,
  input  logic signed [4:0]  w17,
  input  logic signed [4:0]  w24,
  input  logic signed [4:0]  w25,
  input  logic signed [4:0]  w26,
  input  logic signed [4:0]  w27,
  input  logic signed [4:0]  w34,
  input  logic signed [4:0]  w35,
  input  logic signed [4:0]  w36,
  input  logic signed [4:0]  w37,
  output logic               nrn_start,
  output logic signed [4:0]  nrn_in0,
  output logic signed [4:0]  nrn_in1,
  output logic signed [4:0]  nrn_in2,
  output logic signed [4:0]  nrn_in3,
  output logic signed [4:0]  nrn_w0,
  output logic signed [4:0]  nrn_w1,
  output logic signed [4:0]  nrn_w2,
  output logic signed [4:0]  nrn_w3,
  input  logic               nrn_done,
  input  logic signed [11:0] nrn_result,
  output logic signed [11:0] out0,
  output logic signed [11:0] out1,
  output logic signed [11:0] out2,
  output logic signed [11:0] out3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]         idx_reg;
  logic [TW-1:0]      timer_reg;
  logic [3:0]         err_reg;
  logic signed [4:0]  vec_in  [4];
  logic signed [4:0]  in_reg  [4];
  logic signed [4:0]  w_tab   [4][4];   // [input][job]
  logic signed [4:0]  w_pick  [4];
  logic signed [4:0]  w_reg   [4];
  logic signed [11:0] res_reg [4];

  logic       accept;
  logic       load_w;
  logic       job_end;
  logic       job_timeout;
  logic [1:0] w_sel;

  assign vec_in[0] = in0;
  assign vec_in[1] = in1;
  assign vec_in[2] = in2;
  assign vec_in[3] = in3;

  assign w_tab[0][0] = w04;  assign w_tab[0][1] = w05;
  assign w_tab[0][2] = w06;  assign w_tab[0][3] = w07;
  assign w_tab[1][0] = w14;  assign w_tab[1][1] = w15;
  assign w_tab[1][2] = w16;  assign w_tab[1][3] = w17;
  assign w_tab[2][0] = w24;  assign w_tab[2][1] = w25;
  assign w_tab[2][2] = w26;  assign w_tab[2][3] = w27;
  assign w_tab[3][0] = w34;  assign w_tab[3][1] = w35;
  assign w_tab[3][2] = w36;  assign w_tab[3][3] = w37;

  // Weight column for the job about to be issued, one mux per neuron input.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_pick[gi] = w_tab[gi][w_sel];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic plus the strobes that steer the datapath registers.
  // Weights are loaded on the edge that enters ISSUE, so they are already
  // valid during the start pulse and stay frozen through WAIT.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    load_w      = 1'b0;
    job_end     = 1'b0;
    job_timeout = 1'b0;
    w_sel       = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          load_w     = 1'b1;
          w_sel      = 2'd0;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A result arriving on the last allowed cycle still wins.
        if (nrn_done || (timer_reg == TW'(TIMEOUT - 1))) begin
          job_end     = 1'b1;
          job_timeout = !nrn_done;
          if (idx_reg == 2'd3) begin
            state_next = DONE;
          end else begin
            load_w     = 1'b1;
            w_sel      = idx_reg + 2'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: input latch, weight latch, job timer, result/err capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= 2'd0;
      timer_reg <= '0;
      err_reg   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        in_reg[i]  <= '0;
        w_reg[i]   <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        idx_reg <= 2'd0;
        err_reg <= 4'd0;
        for (int i = 0; i < 4; i++) in_reg[i] <= vec_in[i];
      end
      if (load_w) begin
        for (int i = 0; i < 4; i++) w_reg[i] <= w_pick[i];
      end
      if (state_reg == ISSUE) begin
        timer_reg <= '0;
      end else if ((state_reg == WAIT) && !job_end) begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (job_end) begin
        res_reg[idx_reg] <= job_timeout ? 12'sd0 : nrn_result;
        err_reg[idx_reg] <= job_timeout;
        if (idx_reg != 2'd3) idx_reg <= idx_reg + 2'd1;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign nrn_start = (state_reg == ISSUE);
  assign out_valid = (state_reg == DONE);
  assign err       = err_reg;

  assign nrn_in0 = in_reg[0];
  assign nrn_in1 = in_reg[1];
  assign nrn_in2 = in_reg[2];
  assign nrn_in3 = in_reg[3];
  assign nrn_w0  = w_reg[0];
  assign nrn_w1  = w_reg[1];
  assign nrn_w2  = w_reg[2];
  assign nrn_w3  = w_reg[3];
  assign out0    = res_reg[0];
  assign out1    = res_reg[1];
  assign out2    = res_reg[2];
  assign out3    = res_reg[3];

endmodule

// File: tb/tb_hidden_layer_scheduler.sv
// Testbench for hidden_layer_scheduler. A behavioural neuron answers each
// start pulse after a per-job latency (or never). A transaction-level model
// predicts start cycles, the out_valid cycle, results and err flags from the
// accepted vector, the weights and the latencies. The model is checked
// against the DUT on every cycle.
module tb_hidden_layer_scheduler;
  localparam int T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst       = 1'b1;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [4:0]  vin [4];
  logic signed [4:0]  wt  [4][4];   // [input][job]
  logic               in_ready, nrn_start, out_valid, busy;
  logic signed [4:0]  nin [4];
  logic signed [4:0]  nw  [4];
  logic signed [11:0] oo  [4];
  logic [3:0]         err;
  logic               nrn_done;
  logic signed [11:0] nrn_result;

  logic               model_done = 1'b0;
  logic               inj_done   = 1'b0;
  logic signed [11:0] model_res  = '0;
  logic signed [11:0] inj_res    = '0;
  assign nrn_done   = model_done | inj_done;
  assign nrn_result = inj_done ? inj_res : model_res;

  hidden_layer_scheduler #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(vin[0]), .in1(vin[1]), .in2(vin[2]), .in3(vin[3]),
    .w04(wt[0][0]), .w05(wt[0][1]), .w06(wt[0][2]), .w07(wt[0][3]),
    .w14(wt[1][0]), .w15(wt[1][1]), .w16(wt[1][2]), .w17(wt[1][3]),
    .w24(wt[2][0]), .w25(wt[2][1]), .w26(wt[2][2]), .w27(wt[2][3]),
    .w34(wt[3][0]), .w35(wt[3][1]), .w36(wt[3][2]), .w37(wt[3][3]),
    .nrn_start(nrn_start),
    .nrn_in0(nin[0]), .nrn_in1(nin[1]), .nrn_in2(nin[2]), .nrn_in3(nin[3]),
    .nrn_w0(nw[0]), .nrn_w1(nw[1]), .nrn_w2(nw[2]), .nrn_w3(nw[3]),
    .nrn_done(nrn_done), .nrn_result(nrn_result),
    .out0(oo[0]), .out1(oo[1]), .out2(oo[2]), .out3(oo[3]),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_cfg [4];   // neuron latency per job for the next vector; > T means never

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model state.
  bit                 txn_active = 1'b0;
  bit                 chk_reset  = 1'b0;
  int                 t_start [4];
  int                 t_done;
  int                 t_lat [4];
  logic signed [4:0]  t_vec [4];
  logic signed [4:0]  t_w [4][4];
  logic signed [11:0] t_out [4];
  logic [3:0]         t_err;
  logic signed [11:0] last_out [4];
  logic [3:0]         last_err = 4'd0;
  int                 txn_no = 0;
  bit                 pend_ok = 1'b0;
  int                 pend_due = 0;
  logic signed [11:0] pend_res = '0;

  // Behavioural neuron output: result_ready for exactly one cycle when due.
  always @(posedge clk) begin
    #1;
    model_done = pend_ok && (cyc == pend_due);
    model_res  = pend_res;
  end

  // Per-cycle compare against the model, plus neuron start observation.
  always @(negedge clk) begin
    if (rst) begin
      chk_reset  = 1'b1;
      txn_active = 1'b0;
      last_err   = 4'd0;
      for (int i = 0; i < 4; i++) last_out[i] = '0;
    end else begin
      int ks;
      int sum;
      int lat;
      bit ov_exp;
      if (chk_reset) begin
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_nrn_start", nrn_start, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("rst_out%0d", i), oo[i], 0);
          chk($sformatf("rst_nrn_in%0d", i), nin[i], 0);
          chk($sformatf("rst_nrn_w%0d", i), nw[i], 0);
        end
        chk_reset = 1'b0;
      end
      chk("in_ready", in_ready, !txn_active);
      chk("busy", busy, txn_active);
      ks = -1;
      if (txn_active)
        for (int k = 0; k < 4; k++) if (cyc == t_start[k]) ks = k;
      chk("nrn_start", nrn_start, ks >= 0);
      if (nrn_start === 1'b1) begin
        if (ks >= 0) begin
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("job%0d_nrn_w%0d", ks, i), nw[i], t_w[i][ks]);
            chk($sformatf("job%0d_nrn_in%0d", ks, i), nin[i], t_vec[i]);
          end
        end
        lat = (ks >= 0) ? t_lat[ks] : 1;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'(nin[i]) * int'(nw[i]);
        pend_res = 12'(sum);
        pend_ok  = (lat <= T);
        pend_due = cyc + lat;
      end
      ov_exp = txn_active && (cyc >= t_done);
      chk("out_valid", out_valid, ov_exp);
      if (ov_exp) begin
        for (int k = 0; k < 4; k++) chk($sformatf("done_out%0d", k), oo[k], t_out[k]);
        chk("done_err", err, t_err);
      end else if (!txn_active) begin
        for (int k = 0; k < 4; k++) chk($sformatf("idle_out%0d", k), oo[k], last_out[k]);
        chk("idle_err", err, last_err);
      end
      if (ov_exp && out_ready) begin
        $display("[TB] txn %0d: in=%0d,%0d,%0d,%0d out=%0d,%0d,%0d,%0d err=%b",
                 txn_no, t_vec[0], t_vec[1], t_vec[2], t_vec[3],
                 oo[0], oo[1], oo[2], oo[3], err);
        txn_no++;
        for (int k = 0; k < 4; k++) last_out[k] = t_out[k];
        last_err   = t_err;
        txn_active = 1'b0;
      end else if (!txn_active && in_valid) begin
        for (int i = 0; i < 4; i++) begin
          t_vec[i] = vin[i];
          for (int k = 0; k < 4; k++) t_w[i][k] = wt[i][k];
        end
        for (int k = 0; k < 4; k++) t_lat[k] = lat_cfg[k];
        t_start[0] = cyc + 1;
        for (int k = 1; k < 4; k++)
          t_start[k] = t_start[k-1] + ((t_lat[k-1] < T) ? t_lat[k-1] : T) + 1;
        t_done = t_start[3] + ((t_lat[3] < T) ? t_lat[3] : T) + 1;
        for (int k = 0; k < 4; k++) begin
          sum = 0;
          for (int i = 0; i < 4; i++) sum += int'(t_vec[i]) * int'(t_w[i][k]);
          t_out[k] = (t_lat[k] <= T) ? 12'(sum) : 12'sd0;
          t_err[k] = (t_lat[k] > T);
        end
        txn_active = 1'b1;
      end
    end
  end

  task automatic setw(input int a, input int b, input int c, input int d);
    for (int i = 0; i < 4; i++) begin
      wt[i][0] = 5'(a); wt[i][1] = 5'(b); wt[i][2] = 5'(c); wt[i][3] = 5'(d);
    end
  endtask

  task automatic setv(input int a, input int b, input int c, input int d);
    vin[0] = 5'(a); vin[1] = 5'(b); vin[2] = 5'(c); vin[3] = 5'(d);
  endtask

  task automatic randv();
    for (int i = 0; i < 4; i++) vin[i] = 5'($urandom_range(0, 31));
  endtask

  task automatic setlat(input int a, input int b, input int c, input int d);
    lat_cfg[0] = a; lat_cfg[1] = b; lat_cfg[2] = c; lat_cfg[3] = d;
  endtask

  // Raise in_valid and return at the negedge of the accepting cycle.
  task automatic send(output int acc);
    acc = -1;
    in_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    chk("accept_seen", acc >= 0, 1);
  endtask

  task automatic wait_ov(output int at);
    at = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("out_valid_seen", at >= 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, acc3, ov, c, cnt;
    setw(0, 0, 0, 0);
    setv(0, 0, 0, 0);
    setlat(2, 2, 2, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Scenario 1: nominal vector, neuron latency 2.
    @(posedge clk); #1;
    setw(1, -1, 2, 15);
    setv(1, 2, 3, 4);
    send(acc);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(ov);
    chk("s1_latency", ov - acc, 13);
    chk("s1_out0", oo[0], 10);
    chk("s1_out1", oo[1], -10);
    chk("s1_out2", oo[2], 20);
    chk("s1_out3", oo[3], 150);
    chk("s1_err", err, 0);

    // Scenario 2: job 2 never answers and times out.
    @(posedge clk); #1;
    setlat(2, 2, 99, 2);
    send(acc);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(ov);
    chk("s2_latency", ov - acc, 27);
    chk("s2_out2", oo[2], 0);
    chk("s2_out3", oo[3], 150);
    chk("s2_err", err, 4);

    // Scenario 3 and 6: downstream stall, then back-to-back vectors.
    @(posedge clk); #1;
    out_ready = 1'b0;
    setlat($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
    randv();
    send(acc);
    @(posedge clk); #1;
    randv();
    setlat(3, 3, 3, 3);
    wait_ov(ov);
    repeat (5) @(negedge clk);
    chk("s3_in_ready_stall", in_ready, 0);
    chk("s3_out_valid_stall", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    c = cyc;
    send(acc2);
    chk("s3_idle_after_ready", acc2 - c, 1);
    @(posedge clk); #1;
    randv();
    setlat($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5));
    send(acc3);
    chk("s6_throughput", acc3 - acc2, 18);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(ov);

    // Scenario 4: reset while job 1 is waiting.
    @(posedge clk); #1;
    setw(1, -1, 2, 15);
    setv(1, 2, 3, 4);
    setlat(3, 3, 3, 3);
    send(acc);
    @(posedge clk); #1 in_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (nrn_start === 1'b1) cnt++;
      if (cnt == 2) break;
    end
    chk("s4_job1_started", cnt, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("s4_out0_cleared", oo[0], 0);
    chk("s4_err_cleared", err, 0);
    chk("s4_in_ready", in_ready, 1);
    @(posedge clk); #1;
    randv();
    setlat($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
    send(acc);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(ov);

    // Scenario 5: stray done in IDLE and ISSUE, done exactly at the deadline.
    @(posedge clk); #1;
    inj_res  = 12'sh7FF;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    setv(5, -3, 7, 2);
    setw(3, -4, 6, 1);
    setlat(3, 2, 2, T);
    send(acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    wait_ov(ov);
    chk("s5_latency", ov - acc, 28);
    chk("s5_out0", oo[0], 33);
    chk("s5_out3", oo[3], 11);
    chk("s5_err", err, 0);

    // Randomized transactions with random weights, latencies and stalls.
    for (int t = 0; t < 10; t++) begin
      int r;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) wt[i][k] = 5'($urandom_range(0, 31));
      randv();
      for (int k = 0; k < 4; k++) begin
        r = $urandom_range(0, 9);
        lat_cfg[k] = (r == 0) ? 99 : (r == 1) ? T : $urandom_range(1, 5);
      end
      send(acc);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(ov);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hidden_layer_scheduler.md
Name: hidden_layer_scheduler

Overview:
- Time-multiplexes one shared Neuron_12bit across the four hidden-layer neurons (N4..N7). This replaces four parallel neuron instances with one.
- Accepts a 4-element input vector over a valid/ready handshake.
- Issues four sequential neuron jobs, with per-job weight selection, and captures each 12-bit result.
- Presents the full 4-word hidden-layer result downstream over a valid/ready handshake, with a per-job timeout guard.

Parameters:
- TIMEOUT, 16, max WAIT cycles per neuron job before abort (must be ≥2).
- TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream vector valid
- in_ready  output  1  scheduler can accept vector
- in0..in3  input  5 each, signed  layer input vector
- w04..w37  input  5 each, signed (16 ports)  static weights; wIJ = input I to neuron J
- nrn_start  output  1  one-cycle start pulse to the shared neuron (drives its input_ready)
- nrn_in0..nrn_in3  output  5 each, signed  latched inputs to the shared neuron
- nrn_w0..nrn_w3  output  5 each, signed  selected weights; job k drives w0k'..w3k', k'=k+4
- nrn_done  input  1  shared neuron result_ready
- nrn_result  input  12, signed  shared neuron result
- out0..out3  output  12 each, signed  registered results for N4..N7
- out_valid  output  1  result vector valid
- out_ready  input  1  downstream accepts result
- err  output  4  per-job timeout flags, bit k = job k timed out
- busy  output  1  high in any state except IDLE

Behaviour:
Reset:
- State = IDLE; idx = 0; timer = 0.
- out0..3 = 0; err = 0; out_valid = 0; nrn_start = 0; nrn_in*/nrn_w* = 0.
- in_ready is 1 from the first cycle after reset.
- Reset mid-operation aborts the job immediately. No further nrn_start is issued, and a late nrn_done is ignored.

States:
- IDLE
  - in_ready = 1.
  - On in_valid: latch in0..3 into nrn_in0..3, clear err, set idx = 0, go to ISSUE.
  - out0..3 keep their previous values until overwritten.
- ISSUE (1 cycle)
  - nrn_start = 1.
  - nrn_w0..3 = {w0(idx+4), w1(idx+4), w2(idx+4), w3(idx+4)}.
  - timer cleared; go to WAIT.
  - nrn_done in this cycle is ignored.
- WAIT
  - nrn_start = 0; nrn_in*/nrn_w* held stable.
  - If nrn_done: out[idx] <= nrn_result.
  - Else if timer == TIMEOUT-1: out[idx] <= 0 and err[idx] <= 1.
  - Else timer++.
  - On either completion: if idx == 3 go to DONE, else idx++ and go to ISSUE.
  - nrn_done takes priority over timeout in the same cycle.
- DONE
  - out_valid = 1; out0..3 and err stable.
  - On out_ready: go to IDLE, out_valid = 0.

Handshakes and timing:
- in_ready = 0 outside IDLE; no overlap of transactions.
- nrn_start is never asserted outside ISSUE; exactly 4 pulses per transaction.
- nrn_done seen in IDLE or DONE is ignored.
- Latency: with neuron latency L (done L cycles after the start cycle, L ≥ 1), out_valid rises 4L+5 cycles after the accept edge.
- Throughput: one vector per 4L+6 cycles, minimum.
- Arithmetic: no arithmetic on data; results pass through unmodified at 12 bits signed.

Test Plan:
1. in=1,2,3,4; all w*4=1, w*5=-1, w*6=2, w*7=15; behavioural neuron with L=2 -> out0=10, out1=-10 (12'hFF6), out2=20, out3=150, err=0. out_valid exactly 13 cycles after the accept edge. Exactly 4 nrn_start pulses, each with the correct weight set.
2. Same stimulus; bench suppresses nrn_done for job 2, TIMEOUT=16 -> out2=0, err=4'b0100. Other outputs as in scenario 1. Job 3 issued 16 WAIT cycles after job 2's start.
3. out_ready held low 5 cycles after out_valid -> out_valid, out0..3 and err stable. in_ready=0 and in_valid ignored. IDLE is entered the cycle after out_ready=1.
4. Assert rst during WAIT of job 1 -> next cycle: all outputs 0, in_ready=1. A late nrn_done causes no capture. A new vector then completes normally.
5. nrn_done pulses in IDLE, in ISSUE, and simultaneously with timer==TIMEOUT-1 -> first two ignored. The third captures nrn_result with err bit 0.
6. Two back-to-back vectors with in_valid held high -> second accepted only in IDLE after the first DONE handshake. Results correspond to their respective inputs.
